axi_lite_slave_mem: RTL and testbench

Synthesizable AXI4-Lite responder with a word-addressed on-chip memory. It is the slave end of the bus driven by master_dma, and it replaces the behavioural memory model in the DMA benches. Read and write channels run independently. Each channel allows one outstanding transaction.

---
 rtl/axi_lite_slave_mem.sv | 188 ++++++++++++++++++
 tb/tb_axi_lite_slave_mem.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed on-chip memory.
// Independent read and write channels, one outstanding transaction each.
module axi_lite_slave_mem #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 4096,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RVALID,
    input  logic              RREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH) << 2;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    logic [ADDR_W:0] ar_off;
    logic [ADDR_W:0] aw_off;
    logic            ar_hit;
    logic            aw_hit;
    logic [IDX_W-1:0] ar_idx;
    logic [IDX_W-1:0] aw_idx;

    logic [DATA_W-1:0] mem_q [DEPTH];

    rstate_e           rstate_q;
    logic              arready_q;
    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    logic [1:0]        rresp_q;
    logic [15:0]       rd_count_q;

    logic              aw_held_q, aw_held_d;
    logic              w_held_q, w_held_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [15:0]       wr_count_q, wr_count_d;
    logic              commit;

    // One extra bit keeps the offset compare free of wraparound.
    assign ar_off = {1'b0, ARADDR} - {1'b0, BASE_ADDR};
    assign aw_off = {1'b0, awaddr_q} - {1'b0, BASE_ADDR};
    assign ar_hit = (ARADDR >= BASE_ADDR) && (ar_off < SPAN);
    assign aw_hit = (awaddr_q >= BASE_ADDR) && (aw_off < SPAN);
    assign ar_idx = ar_off[IDX_W+1:2];
    assign aw_idx = aw_off[IDX_W+1:2];

    assign commit = aw_held_q && w_held_q && !bvalid_q;

    always_ff @(posedge clk) begin
        if (!reset && commit && aw_hit) begin
            mem_q[aw_idx] <= wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q   <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
            rd_count_q <= '0;
        end else begin
            unique case (rstate_q)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ARVALID && arready_q) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rstate_q  <= R_DATA;
                        if (ar_hit) begin
                            rdata_q <= mem_q[ar_idx];
                            rresp_q <= RESP_OKAY;
                        end else begin
                            rdata_q <= '0;
                            rresp_q <= RESP_DECERR;
                        end
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_count_q <= rd_count_q + 16'd1;
                        rstate_q   <= R_IDLE;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_count_d = wr_count_q;
        if (AWVALID && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = AWADDR;
        end
        if (WVALID && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = WDATA;
        end
        if (commit) begin
            bvalid_d  = 1'b1;
            bresp_d   = aw_hit ? RESP_OKAY : RESP_DECERR;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
        if (bvalid_q && BREADY) begin
            bvalid_d   = 1'b0;
            wr_count_d = wr_count_q + 16'd1;
        end
        // Ready flags are registered from the next-state hold flags.
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_count_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign ARREADY  = arready_q;
    assign RDATA    = rdata_q;
    assign RRESP    = rresp_q;
    assign RVALID   = rvalid_q;
    assign AWREADY  = awready_q;
    assign WREADY   = wready_q;
    assign BVALID   = bvalid_q;
    assign BRESP    = bresp_q;
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Randomized and directed bench for axi_lite_slave_mem.
// Expected values come from a word-indexed reference memory model.
module tb_axi_lite_slave_mem;

    localparam int unsigned DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ARADDR = '0;
    logic        ARVALID = 1'b0;
    logic        ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID;
    logic        RREADY = 1'b0;
    logic [31:0] AWADDR = '0;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int checks = 0;
    int failures = 0;
    int rd_exp = 0;
    int wr_exp = 0;
    logic [31:0] model [int];

    axi_lite_slave_mem #(
        .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .reset(reset),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID),
        .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [31:0] a);
        return (a >= BASE) && ((64'(a) - 64'(BASE)) < 64'(4 * DEPTH));
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    task automatic do_write(input logic [31:0] a,
                            input logic [31:0] d,
                            input int bdly);
        int n;
        bit ha, hw;
        logic [1:0] er;
        er = in_rng(a) ? 2'b00 : 2'b11;
        AWADDR = a; WDATA = d;
        AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while ((AWVALID || WVALID) && n < 20) begin
            ha = AWVALID && AWREADY;
            hw = WVALID && WREADY;
            tick();
            if (ha) AWVALID = 1'b0;
            if (hw) WVALID = 1'b0;
            n++;
        end
        AWVALID = 1'b0; WVALID = 1'b0;
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        repeat (bdly) tick();
        checks++;
        if (BVALID !== 1'b1 || BRESP !== er) begin
            failures++;
            $display("FAIL wr_resp a=%h bvalid=%b bresp=%b exp=1/%b",
                     a, BVALID, BRESP, er);
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        wr_exp++;
        if (in_rng(a)) model[widx(a)] = d;
        checks++;
        if (wr_count !== 16'(wr_exp) || BVALID !== 1'b0) begin
            failures++;
            $display("FAIL wr_count got=%0d bv=%b exp=%0d bv=0",
                     wr_count, BVALID, wr_exp);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input int rdly);
        int n;
        logic [31:0] ed;
        logic [1:0] er;
        ed = 32'h0;
        if (in_rng(a) && model.exists(widx(a))) ed = model[widx(a)];
        er = in_rng(a) ? 2'b00 : 2'b11;
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 20) begin tick(); n++; end
        tick();
        ARVALID = 1'b0;
        n = 0;
        while (!RVALID && n < 20) begin tick(); n++; end
        repeat (rdly) tick();
        checks++;
        if (RVALID !== 1'b1 || RDATA !== ed || RRESP !== er) begin
            failures++;
            $display("FAIL rd a=%h got=%b/%h/%b exp=1/%h/%b",
                     a, RVALID, RDATA, RRESP, ed, er);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        rd_exp++;
        checks++;
        if (rd_count !== 16'(rd_exp)) begin
            failures++;
            $display("FAIL rd_count got=%0d exp=%0d", rd_count, rd_exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if ({ARREADY, AWREADY, WREADY, RVALID, BVALID} !== 5'b0 ||
                RDATA !== 32'h0 || RRESP !== 2'b0 || BRESP !== 2'b0 ||
                rd_count !== 16'h0 || wr_count !== 16'h0) begin
                failures++;
                $display("FAIL reset_outs ar=%b aw=%b w=%b rv=%b bv=%b rd=%h",
                         ARREADY, AWREADY, WREADY, RVALID, BVALID, RDATA);
            end
        end
        reset = 1'b0;
        rd_exp = 0; wr_exp = 0;
        tick();
        checks++;
        if ({ARREADY, AWREADY, WREADY} !== 3'b111 ||
            {RVALID, BVALID} !== 2'b00) begin
            failures++;
            $display("FAIL reset_release rdy=%b%b%b exp=111",
                     ARREADY, AWREADY, WREADY);
        end
    endtask

    task automatic test_basic();
        AWADDR = 32'h2000; WDATA = 32'hAABBCCDD;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b0 || AWREADY !== 1'b0 || WREADY !== 1'b0) begin
            failures++;
            $display("FAIL basic_e1 bv=%b aw=%b w=%b exp=000",
                     BVALID, AWREADY, WREADY);
        end
        tick();
        checks++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            failures++;
            $display("FAIL basic_bvalid got=%b/%b exp=1/00", BVALID, BRESP);
        end
        tick();
        BREADY = 1'b0;
        wr_exp++;
        model[widx(32'h2000)] = 32'hAABBCCDD;
        checks++;
        if (wr_count !== 16'(wr_exp) || BVALID !== 1'b0 ||
            AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            failures++;
            $display("FAIL basic_b_done wc=%0d bv=%b aw=%b w=%b exp=%0d/0/1/1",
                     wr_count, BVALID, AWREADY, WREADY, wr_exp);
        end
        ARADDR = 32'h2000; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'hAABBCCDD ||
            RRESP !== 2'b00 || ARREADY !== 1'b0) begin
            failures++;
            $display("FAIL basic_read got=%b/%h/%b ar=%b exp=1/aabbccdd/00/0",
                     RVALID, RDATA, RRESP, ARREADY);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        rd_exp++;
        checks++;
        if (rd_count !== 16'(rd_exp) || RVALID !== 1'b0 || ARREADY !== 1'b1) begin
            failures++;
            $display("FAIL basic_r_done rc=%0d rv=%b ar=%b exp=%0d/0/1",
                     rd_count, RVALID, ARREADY, rd_exp);
        end
    endtask

    task automatic test_w_before_aw();
        WDATA = 32'h11223344; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        repeat (3) begin
            checks++;
            if (WREADY !== 1'b0 || BVALID !== 1'b0 || AWREADY !== 1'b1) begin
                failures++;
                $display("FAIL wfirst_wait w=%b bv=%b aw=%b exp=0/0/1",
                         WREADY, BVALID, AWREADY);
            end
            tick();
        end
        AWADDR = 32'h2004; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        checks++;
        if (BVALID !== 1'b0) begin
            failures++;
            $display("FAIL wfirst_early_b got=%b exp=0", BVALID);
        end
        tick();
        repeat (5) begin
            checks++;
            if (BVALID !== 1'b1 || BRESP !== 2'b00 ||
                AWREADY !== 1'b0 || WREADY !== 1'b0) begin
                failures++;
                $display("FAIL wfirst_hold bv=%b br=%b aw=%b w=%b exp=1/00/0/0",
                         BVALID, BRESP, AWREADY, WREADY);
            end
            tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        wr_exp++;
        model[widx(32'h2004)] = 32'h11223344;
        checks++;
        if (BVALID !== 1'b0 || wr_count !== 16'(wr_exp) ||
            AWREADY !== 1'b1 || WREADY !== 1'b1) begin
            failures++;
            $display("FAIL wfirst_done bv=%b wc=%0d aw=%b w=%b exp=0/%0d/1/1",
                     BVALID, wr_count, AWREADY, WREADY, wr_exp);
        end
        do_read(32'h2004, 0);
        do_read(32'h2006, 0);
    endtask

    task automatic test_out_of_range();
        do_write(32'h0000_0000, 32'hCAFE0001, 0);
        do_read(32'h4000, 0);
        do_write(32'h4000, 32'hDEADBEEF, 0);
        do_read(32'h0000_0000, 0);
        do_write(32'h3FFC, 32'h0BADF00D, 1);
        do_read(32'h3FFF, 0);
        do_read(32'hFFFF_FFFC, 1);
    endtask

    task automatic test_r_backpressure();
        do_write(32'h1000, 32'h55667788, 0);
        ARADDR = 32'h1000; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        repeat (4) begin
            checks++;
            if (RVALID !== 1'b1 || RDATA !== 32'h55667788 ||
                RRESP !== 2'b00 || ARREADY !== 1'b0) begin
                failures++;
                $display("FAIL rhold rv=%b rd=%h rr=%b ar=%b exp=1/55667788/00/0",
                         RVALID, RDATA, RRESP, ARREADY);
            end
            tick();
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        rd_exp++;
        checks++;
        if (RVALID !== 1'b0 || ARREADY !== 1'b1 || rd_count !== 16'(rd_exp)) begin
            failures++;
            $display("FAIL rhold_done rv=%b ar=%b rc=%0d exp=0/1/%0d",
                     RVALID, ARREADY, rd_count, rd_exp);
        end
    endtask

    task automatic test_collision();
        do_write(32'h2010, 32'hA5A5A5A5, 0);
        AWADDR = 32'h2010; WDATA = 32'h5A5A5A5A;
        AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 32'h2010; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        checks++;
        if (RVALID !== 1'b1 || RDATA !== 32'hA5A5A5A5 || BVALID !== 1'b1) begin
            failures++;
            $display("FAIL collide rv=%b rd=%h bv=%b exp=1/a5a5a5a5/1",
                     RVALID, RDATA, BVALID);
        end
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0; BREADY = 1'b0;
        rd_exp++; wr_exp++;
        model[widx(32'h2010)] = 32'h5A5A5A5A;
        checks++;
        if (rd_count !== 16'(rd_exp) || wr_count !== 16'(wr_exp)) begin
            failures++;
            $display("FAIL collide_cnt rc=%0d wc=%0d exp=%0d/%0d",
                     rd_count, wr_count, rd_exp, wr_exp);
        end
        do_read(32'h2010, 0);
    endtask

    task automatic test_dma_copy();
        logic [31:0] src [4];
        int r0, w0;
        src[0] = 32'hAABBCCDD; src[1] = 32'h11223344;
        src[2] = 32'h55667788; src[3] = 32'h99AABBCC;
        for (int i = 0; i < 4; i++) do_write(32'h1000 + 32'(4 * i), src[i], 0);
        r0 = rd_exp; w0 = wr_exp;
        for (int i = 0; i < 4; i++) begin
            do_read(32'h1000 + 32'(4 * i), i);
            do_write(32'h2000 + 32'(4 * i), src[i], 3 - i);
        end
        checks++;
        if (rd_count !== 16'(r0 + 4) || wr_count !== 16'(w0 + 4)) begin
            failures++;
            $display("FAIL dma_cnt rc=%0d wc=%0d exp=%0d/%0d",
                     rd_count, wr_count, r0 + 4, w0 + 4);
        end
        for (int i = 0; i < 4; i++) do_read(32'h2000 + 32'(4 * i), 0);
    endtask

    task automatic test_reset_mid();
        do_write(32'h2008, 32'hC0C0C0C0, 0);
        WDATA = 32'hD0D0D0D0; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        reset = 1'b1;
        tick();
        checks++;
        if ({ARREADY, AWREADY, WREADY, RVALID, BVALID} !== 5'b0 ||
            rd_count !== 16'h0 || wr_count !== 16'h0) begin
            failures++;
            $display("FAIL midreset_outs rdy=%b%b%b rc=%0d wc=%0d exp=000/0/0",
                     ARREADY, AWREADY, WREADY, rd_count, wr_count);
        end
        reset = 1'b0;
        rd_exp = 0; wr_exp = 0;
        tick();
        checks++;
        if (WREADY !== 1'b1 || AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL midreset_rdy w=%b aw=%b exp=1/1", WREADY, AWREADY);
        end
        AWADDR = 32'h2008; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (BVALID !== 1'b0) begin
                failures++;
                $display("FAIL midreset_stale_w bv=%b exp=0", BVALID);
            end
        end
        do_read(32'h2008, 0);
        WDATA = 32'hE0E0E0E0; WVALID = 1'b1; BREADY = 1'b1;
        tick();
        WVALID = 1'b0;
        tick();
        tick();
        BREADY = 1'b0;
        wr_exp++;
        model[widx(32'h2008)] = 32'hE0E0E0E0;
        do_read(32'h2008, 0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        for (int i = 0; i < 8; i++) do_write(32'h300 + 32'(4 * i), $urandom, 0);
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 5) == 0)
                a = 32'h4000 + 32'($urandom_range(0, 255));
            else
                a = 32'h300 + 32'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1)
                do_write(a, $urandom, $urandom_range(0, 3));
            else
                do_read(a, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_before_aw();
        test_out_of_range();
        test_r_backpressure();
        test_collision();
        test_dma_copy();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
